// File: rtl/uut_result_pkg.sv
// -----------------------------------------------------------------------------
// uut_result_pkg
// Shared types and constants for the UUT result packer.
//   packer_state_t : sequencing states of the packer FSM
//   RECORD_MAGIC   : first byte of every SD record
//   BLOCK_BYTES    : SD block size in bytes (one record per block)
//   HDR_*          : byte offsets of the record header fields
//   crc8_step      : one byte of CRC-8 (poly 0x07, MSB first)
// -----------------------------------------------------------------------------
package uut_result_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    BLK_REQ,
    SEND,
    WAIT_END,
    DONE
  } packer_state_t;

  localparam logic [7:0] RECORD_MAGIC = 8'hA5;
  localparam int         BLOCK_BYTES  = 512;
  localparam int         HDR_FLAGS    = 1;
  localparam int         HDR_COUNT    = 2;
  localparam int         HDR_DATA     = 6;

  // Folds one data byte into the running CRC, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// -----------------------------------------------------------------------------
// crc8_serial
// Byte-wide CRC-8 accumulator (poly 0x07, init 0x00, MSB first).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear back to the init value
//   en        : fold data into the CRC this cycle
//   data      : byte to fold
//   crc       : accumulated CRC (registered)
//   crc_upd   : CRC value that results from folding data now (combinational)
// -----------------------------------------------------------------------------
module crc8_serial
  import uut_result_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc,
  output logic [7:0] crc_upd
);

  assign crc_upd = crc8_step(crc, data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc_upd;
    end
  end

endmodule

// File: rtl/uut_result_packer.sv
// -----------------------------------------------------------------------------
// uut_result_packer
// Measures UUT latency, captures the UUT result/error and writes one 512-byte
// record per run into the SD SPI host byte-write port, one block per run at
// sequential block addresses starting at BASE_ADDR.
// Record: [0]=A5, [1]={6'b0,timeout,err}, [2..5]=cycle count (big-endian),
//         [6..6+N-1]=result (big-endian), optional CRC-8, zero padding.
// Optional feature: define PACKER_CRC_EN to place a CRC-8 over bytes 0..5+N
// at byte 6+N.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start_meas        : pulse, start a run (ignored unless idle)
//   end_uut, err_uut  : UUT finished / error, sampled together
//   output_from_UUT   : UUT result, sampled with end_uut
//   busy, done        : run in progress / one-cycle completion pulse
//   timeout           : sticky, last run hit TIMEOUT_CYCLES
//   spi_busy          : SD host busy
//   spi_w_block       : block-write request
//   spi_w_byte        : byte valid, spi_data_in carries the byte
//   spi_block_addr    : block address of the current record
// -----------------------------------------------------------------------------
module uut_result_packer
  import uut_result_pkg::*;
#(
  parameter int          OUTPUT_SIZE    = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFF0,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_meas,
  input  logic                   end_uut,
  input  logic                   err_uut,
  input  logic [OUTPUT_SIZE-1:0] output_from_UUT,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  input  logic                   spi_busy,
  output logic                   spi_w_block,
  output logic                   spi_w_byte,
  output logic [7:0]             spi_data_in,
  output logic [31:0]            spi_block_addr
);

  localparam int N_BYTES = OUTPUT_SIZE / 8;
`ifdef PACKER_CRC_EN
  localparam int PAD_START = HDR_DATA + N_BYTES + 1;
`else
  localparam int PAD_START = HDR_DATA + N_BYTES;
`endif

  if ((OUTPUT_SIZE % 8) != 0 || OUTPUT_SIZE < 8 || OUTPUT_SIZE > 4000) begin : g_bad_size
    $error("uut_result_packer: OUTPUT_SIZE must be a multiple of 8 in 8..4000");
  end
  if (PAD_START > BLOCK_BYTES) begin : g_bad_fit
    $error("uut_result_packer: record does not fit in one block");
  end

  packer_state_t          state_reg;
  logic [31:0]            count_reg;
  logic [OUTPUT_SIZE-1:0] result_reg;
  logic                   err_reg;
  logic [8:0]             idx_reg;
  logic                   seen_busy_reg;
  logic [8:0]             idx_next;
  logic [7:0]             rec_bytes [BLOCK_BYTES];

  assign idx_next = idx_reg + 9'd1;

`ifdef PACKER_CRC_EN
  logic       transfer;
  logic [7:0] crc_acc;
  logic [7:0] crc_upd;

  // Every byte accepted by the host is folded in; only bytes before the CRC
  // slot matter because the CRC byte is fetched while byte 5+N transfers.
  assign transfer = (state_reg == SEND) && !spi_busy;

  crc8_serial u_crc (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_reg == BLK_REQ),
    .en      (transfer),
    .data    (spi_data_in),
    .crc     (crc_acc),
    .crc_upd (crc_upd)
  );
`endif

  // Static record image; the byte-select mux only ever reads one entry.
  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_rec
    if (gi == 0) begin : g_magic
      assign rec_bytes[gi] = RECORD_MAGIC;
    end else if (gi == HDR_FLAGS) begin : g_flags
      assign rec_bytes[gi] = {6'b0, timeout, err_reg};
    end else if (gi < HDR_DATA) begin : g_count
      assign rec_bytes[gi] = count_reg[8*(HDR_DATA-1-gi) +: 8];
    end else if (gi < HDR_DATA + N_BYTES) begin : g_result
      assign rec_bytes[gi] = result_reg[OUTPUT_SIZE-1-8*(gi-HDR_DATA) -: 8];
`ifdef PACKER_CRC_EN
    end else if (gi == HDR_DATA + N_BYTES) begin : g_crc
      assign rec_bytes[gi] = crc_upd;
`endif
    end else begin : g_pad
      assign rec_bytes[gi] = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= 32'd0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
      idx_reg        <= 9'd0;
      seen_busy_reg  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      spi_w_block    <= 1'b0;
      spi_w_byte     <= 1'b0;
      spi_data_in    <= 8'h00;
      spi_block_addr <= BASE_ADDR;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_meas) begin
            count_reg <= 32'd0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            state_reg <= MEASURE;
          end
        end
        MEASURE: begin
          // end_uut is checked first so it wins over a coincident threshold.
          if (end_uut) begin
            result_reg  <= output_from_UUT;
            err_reg     <= err_uut;
            idx_reg     <= 9'd0;
            spi_w_block <= 1'b1;
            state_reg   <= BLK_REQ;
          end else if (count_reg == TIMEOUT_CYCLES) begin
            timeout     <= 1'b1;
            result_reg  <= '0;
            err_reg     <= 1'b0;
            idx_reg     <= 9'd0;
            spi_w_block <= 1'b1;
            state_reg   <= BLK_REQ;
          end else begin
            count_reg <= count_reg + 32'd1;
          end
        end
        BLK_REQ: begin
          if (spi_busy) begin
            spi_w_block <= 1'b0;
            spi_w_byte  <= 1'b1;
            spi_data_in <= RECORD_MAGIC;
            state_reg   <= SEND;
          end
        end
        SEND: begin
          // The next byte is preloaded on each transfer so spi_data_in is a
          // register and stays put while the host stalls.
          if (!spi_busy) begin
            if (idx_reg == 9'(BLOCK_BYTES - 1)) begin
              spi_w_byte    <= 1'b0;
              spi_data_in   <= 8'h00;
              seen_busy_reg <= 1'b0;
              state_reg     <= WAIT_END;
            end else begin
              idx_reg     <= idx_next;
              spi_data_in <= rec_bytes[idx_next];
            end
          end
        end
        WAIT_END: begin
          if (spi_busy) begin
            seen_busy_reg <= 1'b1;
          end else if (seen_busy_reg) begin
            spi_block_addr <= spi_block_addr + 32'd1;
            done           <= 1'b1;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uut_result_packer.sv
// -----------------------------------------------------------------------------
// tb_uut_result_packer
// Two packer instances: A with the default timeout threshold, B with a
// threshold of 50 cycles. A bench-side SD host model drives spi_busy; a
// monitor pops expected record bytes from a scoreboard queue on every byte
// the host accepts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uut_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start_meas;
  logic [1:0]  end_uut;
  logic [1:0]  err_uut;
  logic [1:0]  spi_busy;
  logic [31:0] result_in;

  wire  [1:0]  busy, done, timeout, spi_w_block, spi_w_byte;
  wire  [7:0]  spi_data_in [2];
  wire  [31:0] spi_block_addr [2];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt [2];
  int xfers = 0;
  bit stall_en = 1'b0;
  int exp_q [$];   // pos*256 + byte value

  always #5 clk = ~clk;

  uut_result_packer #(
    .OUTPUT_SIZE    (32),
    .TIMEOUT_CYCLES (32'hFFFF_FFF0),
    .BASE_ADDR      (32'h0000_0100)
  ) dut_a (
    .clk             (clk),
    .rst             (rst),
    .start_meas      (start_meas[0]),
    .end_uut         (end_uut[0]),
    .err_uut         (err_uut[0]),
    .output_from_UUT (result_in),
    .busy            (busy[0]),
    .done            (done[0]),
    .timeout         (timeout[0]),
    .spi_busy        (spi_busy[0]),
    .spi_w_block     (spi_w_block[0]),
    .spi_w_byte      (spi_w_byte[0]),
    .spi_data_in     (spi_data_in[0]),
    .spi_block_addr  (spi_block_addr[0])
  );

  uut_result_packer #(
    .OUTPUT_SIZE    (32),
    .TIMEOUT_CYCLES (32'd50),
    .BASE_ADDR      (32'h0000_0100)
  ) dut_b (
    .clk             (clk),
    .rst             (rst),
    .start_meas      (start_meas[1]),
    .end_uut         (end_uut[1]),
    .err_uut         (err_uut[1]),
    .output_from_UUT (result_in),
    .busy            (busy[1]),
    .done            (done[1]),
    .timeout         (timeout[1]),
    .spi_busy        (spi_busy[1]),
    .spi_w_block     (spi_w_block[1]),
    .spi_w_byte      (spi_w_byte[1]),
    .spi_data_in     (spi_data_in[1]),
    .spi_block_addr  (spi_block_addr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference CRC-8, poly 0x07, processed one input bit at a time.
  function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic push_record(input logic [7:0] flags, input logic [31:0] cnt, input logic [31:0] res);
    logic [7:0] b [512];
    logic [7:0] crc;
    for (int i = 0; i < 512; i++) b[i] = 8'h00;
    b[0] = 8'hA5;
    b[1] = flags;
    b[2] = cnt[31:24]; b[3] = cnt[23:16]; b[4] = cnt[15:8]; b[5] = cnt[7:0];
    b[6] = res[31:24]; b[7] = res[23:16]; b[8] = res[15:8]; b[9] = res[7:0];
    crc = 8'h00;
    for (int i = 0; i < 10; i++) crc = crc_ref(crc, b[i]);
`ifdef PACKER_CRC_EN
    b[10] = crc;
`endif
    for (int i = 0; i < 512; i++) exp_q.push_back(i * 256 + int'(b[i]));
  endtask

  // SD host model: acknowledges a block request with 3 busy cycles, accepts
  // bytes (optionally with random stalls), then is busy for 4 cycles.
  initial begin
    int h_state [2];
    int h_cnt [2];
    spi_busy = 2'b00;
    h_state[0] = 0; h_state[1] = 0; h_cnt[0] = 0; h_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          h_state[g] = 0;
          spi_busy[g] = 1'b0;
        end else begin
          case (h_state[g])
            0: if (spi_w_block[g]) begin spi_busy[g] = 1'b1; h_cnt[g] = 3; h_state[g] = 1; end
            1: if (h_cnt[g] == 1) begin spi_busy[g] = 1'b0; h_state[g] = 2; end
               else h_cnt[g]--;
            2: if (!spi_w_byte[g]) begin spi_busy[g] = 1'b1; h_cnt[g] = 4; h_state[g] = 3; end
               else spi_busy[g] = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            default: if (h_cnt[g] == 1) begin spi_busy[g] = 1'b0; h_state[g] = 0; end
                     else h_cnt[g]--;
          endcase
        end
      end
    end
  end

  // Monitor: a byte transfers at the next edge when w_byte=1 and busy=0.
  initial begin
    bit         stalled_prev [2];
    logic [7:0] prev_data [2];
    int         e;
    done_cnt[0] = 0; done_cnt[1] = 0;
    stalled_prev[0] = 1'b0; stalled_prev[1] = 1'b0;
    prev_data[0] = 8'h00; prev_data[1] = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          stalled_prev[g] = 1'b0;
        end else begin
          if (done[g]) done_cnt[g]++;
          if (spi_w_byte[g]) begin
            if (stalled_prev[g]) check("stall_hold", {24'd0, spi_data_in[g]}, {24'd0, prev_data[g]});
            if (!spi_busy[g]) begin
              xfers++;
              if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL extra_byte: got 0x%0h, required no transfer", spi_data_in[g]);
              end else begin
                e = exp_q.pop_front();
                check($sformatf("byte%0d", e / 256), {24'd0, spi_data_in[g]}, 32'(e % 256));
              end
            end
            stalled_prev[g] = spi_busy[g];
            prev_data[g] = spi_data_in[g];
          end else begin
            stalled_prev[g] = 1'b0;
          end
        end
      end
    end
  end

  task automatic start_run(input int g);
    @(negedge clk); start_meas[g] = 1'b1;
    @(negedge clk); start_meas[g] = 1'b0;
  endtask

  // end_uut seen at the edge where the counter equals 'cycles'.
  task automatic finish_uut(input int g, input int cycles, input logic [31:0] res, input logic err);
    repeat (cycles) @(negedge clk);
    end_uut[g] = 1'b1; err_uut[g] = err; result_in = res;
    @(negedge clk);
    end_uut[g] = 1'b0; err_uut[g] = 1'b0; result_in = 32'h0;
  endtask

  task automatic wait_done(input int g, input string tag);
    int base;
    int n;
    base = done_cnt[g] - (done[g] ? 1 : 0);
    n = 0;
    while (done_cnt[g] == base && n < 20000) begin @(negedge clk); #2; n++; end
    check({tag, "_done"}, 32'(done_cnt[g]), 32'(base + 1));
    check({tag, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    check({tag, "_one_pulse"}, 32'(done_cnt[g]), 32'(base + 1));
    $display("txn %s: inst %0d done, block_addr=0x%0h timeout=%0b", tag, g, spi_block_addr[g], timeout[g]);
  endtask

  task automatic check_reset_values(input int g, input string tag);
    check({tag, "_busy"},    32'(busy[g]), 32'd0);
    check({tag, "_done"},    32'(done[g]), 32'd0);
    check({tag, "_timeout"}, 32'(timeout[g]), 32'd0);
    check({tag, "_w_block"}, 32'(spi_w_block[g]), 32'd0);
    check({tag, "_w_byte"},  32'(spi_w_byte[g]), 32'd0);
    check({tag, "_data"},    32'(spi_data_in[g]), 32'd0);
    check({tag, "_addr"},    spi_block_addr[g], 32'h100);
  endtask

  initial begin
    int n;
    int target;
    rst = 1'b1; start_meas = 2'b00; end_uut = 2'b00; err_uut = 2'b00; result_in = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values(0, "rstA");
    check_reset_values(1, "rstB");
    rst = 1'b0;

    // Normal run on A: 100 measure cycles, host never stalls.
    push_record(8'h00, 32'd100, 32'hDEADBEEF);
    start_run(0);
    check("normal_busy", 32'(busy[0]), 32'd1);
    finish_uut(0, 100, 32'hDEADBEEF, 1'b0);
    wait_done(0, "normal");
    check("normal_addr", spi_block_addr[0], 32'h101);
    check("normal_idle", 32'(busy[0]), 32'd0);

    // Backpressure on A, with the UUT error flag set.
    stall_en = 1'b1;
    push_record(8'h01, 32'd20, 32'h01020304);
    start_run(0);
    finish_uut(0, 20, 32'h01020304, 1'b1);
    wait_done(0, "stall");
    stall_en = 1'b0;
    check("stall_addr", spi_block_addr[0], 32'h102);

    // Timeout on B (threshold 50), end_uut never asserted.
    push_record(8'h02, 32'd50, 32'h0);
    start_run(1);
    wait_done(1, "timeout");
    check("timeout_flag", 32'(timeout[1]), 32'd1);
    check("timeout_addr", spi_block_addr[1], 32'h101);
    repeat (10) @(negedge clk);
    #1;
    check("timeout_sticky", 32'(timeout[1]), 32'd1);

    // end_uut coincides with the threshold; start pulsed during SEND.
    push_record(8'h00, 32'd50, 32'h12345678);
    start_run(1);
    check("timeout_cleared", 32'(timeout[1]), 32'd0);
    finish_uut(1, 50, 32'h12345678, 1'b0);
    n = 0;
    while (!spi_w_byte[1] && n < 200) begin @(negedge clk); n++; end
    check("reach_send", 32'(spi_w_byte[1]), 32'd1);
    start_run(1);
    wait_done(1, "coincident");
    check("coincident_timeout", 32'(timeout[1]), 32'd0);
    check("coincident_addr", spi_block_addr[1], 32'h102);
    repeat (150) @(negedge clk);
    #2;
    check("ignored_start_busy", 32'(busy[1]), 32'd0);
    check("ignored_start_done", 32'(done_cnt[1]), 32'd2);

    // Reset while A is sending byte 200.
    push_record(8'h00, 32'd5, 32'hCAFEF00D);
    target = xfers + 200;
    start_run(0);
    finish_uut(0, 5, 32'hCAFEF00D, 1'b0);
    n = 0;
    while (xfers < target && n < 5000) begin @(negedge clk); #2; n++; end
    check("reach_idx200", 32'(xfers), 32'(target));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values(0, "midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    $display("txn midrst: inst 0 reset at byte 200");

    push_record(8'h00, 32'd7, 32'h0BADC0DE);
    start_run(0);
    finish_uut(0, 7, 32'h0BADC0DE, 1'b0);
    wait_done(0, "after_rst");
    check("after_rst_addr", spi_block_addr[0], 32'h101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
